// File: rtl/serial_io_init_sequencer.sv
// serial_io_init_sequencer: writes a fixed 7-register 16550 init sequence into each selected UART port
module serial_io_init_sequencer #(
    parameter int          NUM_PORTS     = 5,
    parameter logic [15:0] BASE_ADDR     = 16'h0200,
    parameter logic [15:0] PORT_STRIDE   = 16'h0010,
    parameter logic [15:0] DIVISOR       = 16'd27,
    parameter logic [7:0]  LCR_VALUE     = 8'h03,
    parameter int          STROBE_CYCLES = 2
) (
    input  logic                 Clock,
    input  logic                 Reset_H,
    input  logic                 Start_H,
    input  logic [NUM_PORTS-1:0] PortMask,
    input  logic                 BusGnt_H,
    output logic                 BusReq_H,
    output logic [15:0]          Address,
    output logic                 IOSelect_H,
    output logic                 ByteSelect_L,
    output logic                 WE_L,
    output logic [7:0]           DataOut,
    output logic                 Busy_H,
    output logic                 Done_H
);
    localparam int PW = $clog2(NUM_PORTS + 1);
    typedef enum logic [2:0] {IDLE, LOAD, REQ, SETUP, STROBE, HOLD, NEXT, DONE} state_t;
    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] mask_q, mask_d, rem;
    logic [PW-1:0]        port_q, port_d, low;
    logic [2:0]           step_q, step_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0]           offset;
    logic [7:0]           data;
    logic                 any, on_bus;
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            state_q <= IDLE;
            mask_q  <= '0;
            port_q  <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            port_q  <= port_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end
    // remaining ports: the whole latched mask in LOAD, minus the finished port afterwards
    always_comb begin
        rem = (state_q == LOAD) ? mask_q : mask_q & ~(NUM_PORTS'(1) << port_q);
        any = |rem;
        low = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (rem[i]) low = PW'(i);
    end
    always_comb begin
        case (step_q)
            3'd0:    {offset, data} = {4'h6, 8'h80};
            3'd1:    {offset, data} = {4'h0, DIVISOR[7:0]};
            3'd2:    {offset, data} = {4'h2, DIVISOR[15:8]};
            3'd3:    {offset, data} = {4'h6, LCR_VALUE};
            3'd4:    {offset, data} = {4'h4, 8'h06};
            3'd5:    {offset, data} = {4'h4, 8'h00};
            default: {offset, data} = {4'h2, 8'h00};
        endcase
    end
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        port_d  = port_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (Start_H) begin
                state_d = LOAD;
                mask_d  = PortMask;
            end
            LOAD: begin
                port_d  = low;
                step_d  = '0;
                state_d = any ? REQ : DONE;
            end
            REQ: if (BusGnt_H) state_d = SETUP;
            SETUP: begin
                cnt_d   = '0;
                state_d = BusGnt_H ? STROBE : REQ;
            end
            STROBE: begin
                if (!BusGnt_H) state_d = REQ;
                else if (cnt_q == 4'(STROBE_CYCLES - 1)) state_d = HOLD;
                else cnt_d = cnt_q + 4'd1;
            end
            HOLD: state_d = BusGnt_H ? NEXT : REQ;
            NEXT: begin
                if (step_q != 3'd6) begin
                    step_d  = step_q + 3'd1;
                    state_d = REQ;
                end else begin
                    mask_d  = rem;
                    port_d  = low;
                    step_d  = '0;
                    state_d = any ? REQ : DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign on_bus       = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
    assign BusReq_H     = on_bus || (state_q == REQ);
    assign IOSelect_H   = on_bus;
    assign ByteSelect_L = !on_bus;
    assign WE_L         = state_q != STROBE;
    assign Address      = on_bus ? BASE_ADDR + 16'(port_q) * PORT_STRIDE + {12'h000, offset} : 16'h0000;
    assign DataOut      = on_bus ? data : 8'h00;
    assign Busy_H       = state_q != IDLE;
    assign Done_H       = state_q == DONE;
endmodule

// File: tb/tb_serial_io_init_sequencer.sv
// tb_serial_io_init_sequencer: directed and random checks of the UART init sequencer against a write-list model
module tb_serial_io_init_sequencer;
    logic        Clock = 0, Reset_H = 1, Start_H = 0, BusGnt_H = 1;
    logic [4:0]  PortMask = '0;
    logic        BusReq_H, IOSelect_H, ByteSelect_L, WE_L, Busy_H, Done_H;
    logic [15:0] Address;
    logic [7:0]  DataOut;
    int total = 0, bad = 0;
    int wq_addr[$], wq_data[$], wq_len[$];
    int breq_n = 0, iosel_n = 0, done_n = 0, unstable_n = 0, abort_n = 0, low_len = 0;
    logic prev_we_low = 0, prev_iosel = 0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    int OFF[7] = '{6, 0, 2, 6, 4, 4, 2};
    int DAT[7] = '{8'h80, 27 % 256, 27 / 256, 8'h03, 8'h06, 8'h00, 8'h00};
    serial_io_init_sequencer dut (
        .Clock(Clock), .Reset_H(Reset_H), .Start_H(Start_H), .PortMask(PortMask),
        .BusGnt_H(BusGnt_H), .BusReq_H(BusReq_H), .Address(Address), .IOSelect_H(IOSelect_H),
        .ByteSelect_L(ByteSelect_L), .WE_L(WE_L), .DataOut(DataOut), .Busy_H(Busy_H), .Done_H(Done_H)
    );
    always #5 Clock = ~Clock;
    // a completed write is a WE_L low run that ends with IOSelect_H still high
    always @(negedge Clock) begin
        if (BusReq_H) breq_n++;
        if (IOSelect_H) iosel_n++;
        if (Done_H) done_n++;
        if (IOSelect_H && prev_iosel && (Address !== prev_addr || DataOut !== prev_data)) unstable_n++;
        if (!WE_L) low_len++;
        else begin
            if (prev_we_low && IOSelect_H) begin
                wq_addr.push_back(int'(Address));
                wq_data.push_back(int'(DataOut));
                wq_len.push_back(low_len);
            end else if (prev_we_low) abort_n++;
            low_len = 0;
        end
        prev_we_low = !WE_L;
        prev_iosel  = IOSelect_H;
        prev_addr   = Address;
        prev_data   = DataOut;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge Clock);
        #1;
    endtask
    task automatic check_idle(input string tag);
        chk({tag, ".breq"}, 32'(BusReq_H), 0);
        chk({tag, ".addr"}, 32'(Address), 0);
        chk({tag, ".iosel"}, 32'(IOSelect_H), 0);
        chk({tag, ".bsel"}, 32'(ByteSelect_L), 1);
        chk({tag, ".we"}, 32'(WE_L), 1);
        chk({tag, ".data"}, 32'(DataOut), 0);
        chk({tag, ".busy"}, 32'(Busy_H), 0);
        chk({tag, ".done"}, 32'(Done_H), 0);
    endtask
    task automatic pulse_start(input logic [4:0] m);
        tick();
        Start_H  = 1;
        PortMask = m;
        tick();
        Start_H  = 0;
    endtask
    // cycle 1 is the cycle right after the edge that accepted Start_H
    task automatic wait_done(input string tag, input bit rnd, output int cyc);
        cyc = 1;
        while (!Done_H && cyc < 3000) begin
            if (rnd) BusGnt_H = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        BusGnt_H = 1;
        chk({tag, ".done_seen"}, 32'(Done_H), 1);
        tick();
        chk({tag, ".done_width"}, 32'(Done_H), 0);
    endtask
    task automatic check_seq(input string tag, input logic [4:0] m, input int base, input bit collapse);
        int ea[$], ed[$], oa[$], od[$];
        int len_bad = 0;
        for (int p = 0; p < 5; p++)
            if (m[p])
                for (int s = 0; s < 7; s++) begin
                    ea.push_back((16'h0200 + p * 16'h0010 + OFF[s]) & 16'hFFFF);
                    ed.push_back(DAT[s]);
                end
        for (int i = base; i < wq_addr.size(); i++) begin
            if (wq_len[i] != 2) len_bad++;
            if (collapse && oa.size() > 0 && oa[$] == wq_addr[i] && od[$] == wq_data[i]) continue;
            oa.push_back(wq_addr[i]);
            od.push_back(wq_data[i]);
        end
        chk({tag, ".count"}, 32'(oa.size()), 32'(ea.size()));
        for (int i = 0; i < oa.size() && i < ea.size(); i++)
            chk($sformatf("%s.w%0d", tag, i), 32'({oa[i][15:0], od[i][7:0]}), 32'({ea[i][15:0], ed[i][7:0]}));
        chk({tag, ".we_width"}, 32'(len_bad), 0);
    endtask
    initial begin
        int cyc, base, snap_b, snap_i, snap_d, snap_a;
        logic [4:0] m;
        repeat (3) tick();
        check_idle("reset");
        Reset_H = 0;
        snap_b = breq_n;
        repeat (6) tick();
        check_idle("idle");
        chk("idle.breq_cnt", 32'(breq_n - snap_b), 0);
        base = wq_addr.size();
        snap_d = done_n;
        pulse_start(5'b00001);
        wait_done("p0", 0, cyc);
        chk("p0.done_cycle", 32'(cyc), 44);
        chk("p0.done_cnt", 32'(done_n - snap_d), 1);
        check_seq("p0", 5'b00001, base, 0);
        base = wq_addr.size();
        pulse_start(5'b10100);
        wait_done("p24", 0, cyc);
        check_seq("p24", 5'b10100, base, 0);
        snap_b = breq_n;
        snap_i = iosel_n;
        pulse_start(5'b00000);
        wait_done("none", 0, cyc);
        chk("none.done_cycle", 32'(cyc), 2);
        chk("none.breq_cnt", 32'(breq_n - snap_b), 0);
        chk("none.iosel_cnt", 32'(iosel_n - snap_i), 0);
        base = wq_addr.size();
        BusGnt_H = 0;
        pulse_start(5'b00001);
        snap_i = iosel_n;
        repeat (10) tick();
        chk("nogrant.iosel_cnt", 32'(iosel_n - snap_i), 0);
        chk("nogrant.breq", 32'(BusReq_H), 1);
        BusGnt_H = 1;
        wait_done("nogrant", 0, cyc);
        check_seq("nogrant", 5'b00001, base, 0);
        base = wq_addr.size();
        snap_a = abort_n;
        pulse_start(5'b00010);
        cyc = 0;
        while (WE_L && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("drop.strobe_seen", 32'(WE_L), 0);
        BusGnt_H = 0;
        tick();
        chk("drop.we_rise", 32'(WE_L), 1);
        chk("drop.iosel_low", 32'(IOSelect_H), 0);
        repeat (3) tick();
        BusGnt_H = 1;
        wait_done("drop", 0, cyc);
        check_seq("drop", 5'b00010, base, 0);
        chk("drop.aborts", 32'(abort_n - snap_a), 1);
        base = wq_addr.size();
        snap_d = done_n;
        pulse_start(5'b00001);
        repeat (8) tick();
        Start_H  = 1;
        PortMask = 5'b11111;
        tick();
        Start_H  = 0;
        wait_done("busystart", 0, cyc);
        check_seq("busystart", 5'b00001, base, 0);
        chk("busystart.done_cnt", 32'(done_n - snap_d), 1);
        snap_b = breq_n;
        repeat (5) tick();
        chk("busystart.not_queued", 32'(breq_n - snap_b), 0);
        base = wq_addr.size();
        pulse_start(5'b00001);
        cyc = 0;
        while (!(wq_addr.size() - base == 3 && !WE_L) && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("rst.step3_strobe", 32'(WE_L), 0);
        Reset_H = 1;
        tick();
        check_idle("rst_mid");
        Reset_H = 0;
        tick();
        base = wq_addr.size();
        pulse_start(5'b00001);
        wait_done("restart", 0, cyc);
        chk("restart.done_cycle", 32'(cyc), 44);
        check_seq("restart", 5'b00001, base, 0);
        for (int k = 0; k < 6; k++) begin
            m = 5'($urandom_range(0, 31));
            base = wq_addr.size();
            pulse_start(m);
            wait_done($sformatf("rnd%0d", k), 1, cyc);
            check_seq($sformatf("rnd%0d", k), m, base, 1);
        end
        chk("stable", 32'(unstable_n), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
